mux8_rr_arbiter: RTL and testbench

MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

---
 rtl/mux8_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter over eight 1-bit sources that feeds an 8:1 data mux.
// Each owner keeps the grant for at most MAX_HOLD consecutive cycles.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic [7:0] data_in,
  output logic [7:0] gnt,
  output logic [2:0] Sel,
  output logic       mux81out,
  output logic       dvalid,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t     state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [3:0] hold_reg, hold_next;
  logic [7:0] gnt_reg, gnt_next;
  logic [2:0] sel_reg, sel_next;
  logic       mux81out_reg;
  logic       dvalid_reg;

  logic       rel;
  logic [2:0] base;
  logic [7:0] req_rot;
  logic [2:0] win_off;
  logic [2:0] win_idx;
  logic [7:0] win_onehot;

  // On a release the pointer advances past the owner in the same edge, so the
  // winner is chosen against the updated priority rather than the stale one.
  assign rel  = (state_reg == GRANT) &&
                (!req[sel_reg] || (hold_reg == MAX_HOLD_C) || !en);
  assign base = rel ? (sel_reg + 3'd1) : ptr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign req_rot[gi]    = req[3'(gi) + base];
      assign win_onehot[gi] = (win_idx == 3'(gi));
    end
  endgenerate

  always_comb begin
    win_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (req_rot[k]) win_off = 3'(k);
    end
  end

  assign win_idx = base + win_off;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    hold_next  = hold_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    case (state_reg)
      IDLE: begin
        if (en && (req != 8'd0)) begin
          state_next = GRANT;
          gnt_next   = win_onehot;
          sel_next   = win_idx;
          hold_next  = 4'd1;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_next = base;
          if (en && (req != 8'd0)) begin
            gnt_next  = win_onehot;
            sel_next  = win_idx;
            hold_next = 4'd1;
          end else begin
            state_next = IDLE;
            gnt_next   = 8'd0;
            hold_next  = 4'd0;
          end
        end else if (hold_reg != 4'hF) begin
          hold_next = hold_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= 3'd0;
      hold_reg     <= 4'd0;
      gnt_reg      <= 8'd0;
      sel_reg      <= 3'd0;
      mux81out_reg <= 1'b0;
      dvalid_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_reg     <= hold_next;
      gnt_reg      <= gnt_next;
      sel_reg      <= sel_next;
      // Data and valid use the pre-edge select and busy, hence one cycle of latency.
      mux81out_reg <= data_in[sel_reg];
      dvalid_reg   <= (state_reg == GRANT);
    end
  end

  assign gnt      = gnt_reg;
  assign Sel      = sel_reg;
  assign mux81out = mux81out_reg;
  assign dvalid   = dvalid_reg;
  assign busy     = (state_reg == GRANT);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with MAX_HOLD=4; inputs change and
// outputs are sampled on the falling clock edge.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] data_in;
  logic [7:0] gnt;
  logic [2:0] Sel;
  logic       mux81out;
  logic       dvalid;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .req(req), .data_in(data_in),
    .gnt(gnt), .Sel(Sel), .mux81out(mux81out), .dvalid(dvalid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; en = 1'b0; req = 8'd0; data_in = 8'd0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({gnt, Sel, mux81out, dvalid, busy} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_state: gnt=%h Sel=%0d mux=%b dvalid=%b busy=%b, required all 0",
               gnt, Sel, mux81out, dvalid, busy);
    end
    reset_n = 1'b1;
    $display("reset: gnt=%h Sel=%0d busy=%b", gnt, Sel, busy);
  endtask

  task automatic test_single();
    en = 1'b1; req = 8'h04;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (gnt !== 8'h04 || Sel !== 3'd2 || busy !== 1'b1 || dvalid !== (i >= 2)) begin
        n_err++;
        $display("FAIL single_cycle%0d: gnt=%h Sel=%0d busy=%b dvalid=%b, required 04/2/1/%b",
                 i, gnt, Sel, busy, dvalid, (i >= 2));
      end
      $display("single c%0d: gnt=%h Sel=%0d dvalid=%b", i, gnt, Sel, dvalid);
    end
    req = 8'h00;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 8'h00 || busy !== 1'b0 || Sel !== 3'd2) begin
      n_err++;
      $display("FAIL single_idle: gnt=%h busy=%b Sel=%0d, required 00/0/2", gnt, busy, Sel);
    end
    $display("single idle: gnt=%h Sel=%0d busy=%b", gnt, Sel, busy);
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_sel;
    logic [7:0] exp_gnt;
    do_reset();
    en = 1'b1; req = 8'hFF;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      exp_sel = 3'((c / 4) % 8);
      exp_gnt = 8'h01 << exp_sel;
      n_cmp++;
      if (gnt !== exp_gnt || Sel !== exp_sel || busy !== 1'b1) begin
        n_err++;
        $display("FAIL rr_cycle%0d: gnt=%h Sel=%0d busy=%b, required %h/%0d/1",
                 c, gnt, Sel, busy, exp_gnt, exp_sel);
      end
      $display("rr c%0d: gnt=%h Sel=%0d", c, gnt, Sel);
    end
  endtask

  task automatic test_early_drop_wrap();
    do_reset();
    en = 1'b1; req = 8'h28;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (Sel !== 3'd3 || gnt !== 8'h08) begin
        n_err++;
        $display("FAIL drop_owner3: gnt=%h Sel=%0d, required 08/3", gnt, Sel);
      end
    end
    req = 8'h20;
    @(negedge clk);
    n_cmp++;
    if (Sel !== 3'd5 || gnt !== 8'h20 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL drop_to5: gnt=%h Sel=%0d busy=%b, required 20/5/1", gnt, Sel, busy);
    end
    $display("drop: gnt=%h Sel=%0d busy=%b", gnt, Sel, busy);
    req = 8'h40;
    @(negedge clk);
    n_cmp++;
    if (Sel !== 3'd6 || gnt !== 8'h40) begin
      n_err++;
      $display("FAIL wrap_owner6: gnt=%h Sel=%0d, required 40/6", gnt, Sel);
    end
    req = 8'h81;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (Sel !== 3'd7 || gnt !== 8'h80) begin
        n_err++;
        $display("FAIL wrap_owner7_c%0d: gnt=%h Sel=%0d, required 80/7", i, gnt, Sel);
      end
      $display("wrap c%0d: gnt=%h Sel=%0d", i, gnt, Sel);
    end
    @(negedge clk);
    n_cmp++;
    if (Sel !== 3'd0 || gnt !== 8'h01 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_owner0: gnt=%h Sel=%0d busy=%b, required 01/0/1", gnt, Sel, busy);
    end
    $display("wrap next: gnt=%h Sel=%0d", gnt, Sel);
  endtask

  task automatic test_datapath();
    logic [7:0] dv [3];
    logic       ex [3];
    dv[0] = 8'h20; dv[1] = 8'hDF; dv[2] = 8'h3F;
    ex[0] = 1'b1;  ex[1] = 1'b0;  ex[2] = 1'b1;
    do_reset();
    en = 1'b1; req = 8'h20;
    @(negedge clk);
    n_cmp++;
    if (Sel !== 3'd5) begin
      n_err++;
      $display("FAIL data_sel: Sel=%0d, required 5", Sel);
    end
    for (int j = 0; j < 3; j++) begin
      data_in = dv[j];
      @(negedge clk);
      n_cmp++;
      if (mux81out !== ex[j] || dvalid !== 1'b1) begin
        n_err++;
        $display("FAIL data_%0d: mux81out=%b dvalid=%b, required %b/1", j, mux81out, dvalid, ex[j]);
      end
      $display("data %0d: data_in=%h mux81out=%b dvalid=%b", j, dv[j], mux81out, dvalid);
    end
  endtask

  task automatic test_async_reset_en();
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, Sel, mux81out, dvalid, busy} !== 14'd0) begin
      n_err++;
      $display("FAIL async_reset: gnt=%h Sel=%0d mux=%b dvalid=%b busy=%b, required all 0",
               gnt, Sel, mux81out, dvalid, busy);
    end
    $display("async reset: gnt=%h Sel=%0d mux=%b dvalid=%b busy=%b", gnt, Sel, mux81out, dvalid, busy);
    en = 1'b0; req = 8'hFF;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (gnt !== 8'h00 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL en_low_c%0d: gnt=%h busy=%b, required 00/0", i, gnt, busy);
      end
    end
    en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 8'h01 || Sel !== 3'd0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL en_high: gnt=%h Sel=%0d busy=%b, required 01/0/1", gnt, Sel, busy);
    end
    en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 8'h00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL en_drop: gnt=%h busy=%b, required 00/0", gnt, busy);
    end
    $display("en drop: gnt=%h Sel=%0d busy=%b", gnt, Sel, busy);
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; req = 8'd0; data_in = 8'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_early_drop_wrap();
    test_datapath();
    test_async_reset_en();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
